// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency instruction memory and
// delivers words over valid/ready, using an output register plus 1-entry skid buffer.
module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pending_pc_reg;
  logic              pending_reg;
  logic              drop_reg;

  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic              instr_valid_reg;

  logic [DATA_W-1:0] skid_data_reg;
  logic [ADDR_W-1:0] skid_pc_reg;
  logic              skid_valid_reg;

  logic stall;
  logic accept;
  logic issue;
  logic ret;

  assign stall  = instr_valid_reg & ~instr_ready;
  assign accept = instr_valid_reg & instr_ready;
  // Issuing only when nothing can back up keeps the skid buffer from overflowing.
  assign issue  = rst_n & en & ~jump & ~skid_valid_reg & ~stall;
  assign ret    = pending_reg & ~drop_reg;

  assign mem_rd      = issue;
  assign mem_address = pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg         <= RESET_PC;
      pending_pc_reg <= '0;
      pending_reg    <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      pending_reg <= issue;
      // A read still in flight across a redirect must be discarded when it lands.
      drop_reg    <= jump & issue;
      if (jump) begin
        pc_reg <= jump_addr;
      end else if (issue) begin
        pc_reg         <= pc_reg + ADDR_W'(1);
        pending_pc_reg <= pc_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      skid_data_reg   <= '0;
      skid_pc_reg     <= '0;
      skid_valid_reg  <= 1'b0;
    end else if (jump) begin
      instr_valid_reg <= 1'b0;
      skid_valid_reg  <= 1'b0;
    end else if (ret) begin
      if (!instr_valid_reg || (accept && !skid_valid_reg)) begin
        instr_reg       <= mem_dout;
        instr_pc_reg    <= pending_pc_reg;
        instr_valid_reg <= 1'b1;
      end else if (accept) begin
        instr_reg     <= skid_data_reg;
        instr_pc_reg  <= skid_pc_reg;
        skid_data_reg <= mem_dout;
        skid_pc_reg   <= pending_pc_reg;
      end else begin
        skid_data_reg  <= mem_dout;
        skid_pc_reg    <= pending_pc_reg;
        skid_valid_reg <= 1'b1;
      end
    end else if (accept) begin
      if (skid_valid_reg) begin
        instr_reg      <= skid_data_reg;
        instr_pc_reg   <= skid_pc_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        instr_valid_reg <= 1'b0;
      end
    end
  end

  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(~jump & ret & stall & skid_valid_reg));

endmodule
